sd4_sum_normalizer: RTL and testbench
=====================================

// Module: sd4_sum_normalizer
// PURPOSE
//  Consumes the 20-bit unsigned accumulator magnitude and the registered leading-one
//  index from leadingone_detector1; produces a normalized, rounded (sign, exp, mant).
//  Sits directly downstream of the detector in the SD4 MAC output path; both are fed
//  the same unsign_sum in the same cycle. Results are buffered in a small FIFO with a
//  valid/ready output handshake toward the quantize/writeback stage.
// PARAMETERS
//  SUM_W       20  magnitude width; fixed to match detector (5-bit index)
//  MANT_W      8   output mantissa width incl. explicit leading one (2..SUM_W)
//  FIFO_DEPTH  2   output buffer entries (power of 2, >=2)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  in_valid     in   1       unsign_sum/in_sign valid this cycle (no input backpressure)
//  in_sign      in   1       sign of the accumulated result
//  unsign_sum   in   SUM_W   magnitude; same value presented to the detector
//  leading_one  in   5       detector output; valid one cycle after unsign_sum
//  out_valid    out  1       FIFO head holds a result
//  out_ready    in   1       consumer accepts head when out_valid & out_ready
//  out_sign     out  1       result sign (0 when out_zero)
//  out_zero     out  1       magnitude was zero
//  out_exp      out  5       leading-one position after rounding, 0..20
//  out_mant     out  MANT_W  normalized mantissa, MSB = leading one (0 when zero)
//  overflow     out  1       sticky: a result was dropped on a full FIFO
// BEHAVIOUR
//  - Reset: out_valid=0, overflow=0, FIFO empty, align valid=0; out_* data = 0.
//    The detector has no reset; its output is ignored until an aligned valid.
//  - Align stage: edge ending cycle T captures in_valid, in_sign, unsign_sum; in T+1
//    these pair with leading_one (lo) for the cycle-T sum.
//  - Normalize (combinational in T+1): sh = sum << (19-lo); mant = sh[19 -: MANT_W];
//    guard = sh[19-MANT_W]; sticky = |sh[18-MANT_W:0]. lo < MANT_W-1 -> low bits zero-
//    filled, guard=sticky=0, exact.
//  - Round to nearest, ties to even: inc = guard & (sticky | mant[0]). Carry out
//    (mant all ones + 1) -> mant = 1<<(MANT_W-1), exp = lo+1 (max 20); else exp = lo.
//  - Zero: aligned sum==0 -> out_zero=1, mant=0, exp=0, sign=0 (detector lo ignored).
//  - Push at edge ending T+1; out_valid earliest in T+2 (latency 2). One result per
//    cycle sustained when out_ready=1.
//  - FIFO: pop when out_valid & out_ready; head data held stable while out_valid &
//    !out_ready. Push+pop same cycle when full: both occur, no drop. Push when full
//    and no pop: result dropped, overflow set, FIFO unchanged. Pointers wrap modulo
//    FIFO_DEPTH; count spans 0..FIFO_DEPTH.
//  - out_* data reads 0 whenever out_valid=0.
//  - rst mid-stream: FIFO and in-flight aligned result discarded next edge; a valid
//    input during the rst cycle is not captured.
// TESTING (MANT_W=8)
//  sum=0x00001, sign=0 -> exp=0, mant=0x80, zero=0; out_valid exactly 2 cycles later.
//  sum=0x00101 -> exp=8, mant=0x80 (tie, even kept); sum=0x00103 -> mant=0x82.
//  sum=0xFF800 -> exp=20, mant=0x80 (round-up carry); sum=0x80000 -> exp=19, mant=0x80.
//  sum=0, sign=1 -> out_zero=1, out_sign=0, exp=0, mant=0.
//  out_ready=0, three back-to-back inputs -> first two held, third dropped, overflow=1;
//    then out_ready=1 -> two results popped in order, out_valid falls, overflow stays 1.
//  rst asserted while FIFO holds 2 entries and one in flight -> out_valid=0 and
//    overflow=0 next cycle; no stale result appears afterwards.

Source files
------------

// File: rtl/sd4_sum_normalizer.sv
// sd4_sum_normalizer: normalizes and rounds (nearest, ties to even) the SD4 MAC
// accumulator magnitude using the leading-one index from the upstream detector,
// then buffers (sign, zero, exp, mant) results in a small valid/ready FIFO.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid, in_sign     input qualifier and sign of the accumulated result
//   unsign_sum [SUM_W]    magnitude, also presented to the detector this cycle
//   leading_one [5]       detector index, arrives one cycle after unsign_sum
//   out_valid, out_ready  output handshake; head popped when both are high
//   out_sign, out_zero    result sign (0 for zero) and zero flag
//   out_exp [5]           leading-one position after rounding, 0..20
//   out_mant [MANT_W]     normalized mantissa with explicit leading one
//   overflow              sticky flag: a result was dropped on a full FIFO
module sd4_sum_normalizer #(
    parameter int unsigned SUM_W      = 20,
    parameter int unsigned MANT_W     = 8,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sign,
    input  logic [SUM_W-1:0]  unsign_sum,
    input  logic [4:0]        leading_one,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic              out_zero,
    output logic [4:0]        out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              overflow
);

    localparam int unsigned EXP_W = 5;
    localparam int unsigned MSB   = SUM_W - 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned EXT_W = SUM_W + 2;

    typedef struct packed {
        logic              sign;
        logic              zero;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } res_t;

    // ---------------------------------------------------------------
    // Align stage: hold the sum one cycle so it meets its leading-one index
    // ---------------------------------------------------------------
    logic             al_valid_q, al_valid_d;
    logic             al_sign_q,  al_sign_d;
    logic [SUM_W-1:0] al_sum_q,   al_sum_d;

    always_comb begin
        al_valid_d = in_valid;
        al_sign_d  = al_sign_q;
        al_sum_d   = al_sum_q;
        if (in_valid) begin
            al_sign_d = in_sign;
            al_sum_d  = unsign_sum;
        end
    end

    // ---------------------------------------------------------------
    // Normalize and round the aligned sum
    // ---------------------------------------------------------------
    logic [EXP_W-1:0]  sh_amt_c;
    logic [SUM_W-1:0]  sh_c;
    logic [EXT_W-1:0]  ext_c;
    logic [MANT_W-1:0] mant_c;
    logic              guard_c;
    logic              sticky_c;
    logic              inc_c;
    logic [MANT_W:0]   mant_rnd_c;
    res_t              res_c;

    always_comb begin
        // Out-of-range indices cannot occur for a nonzero sum; clamp to keep the shift bounded.
        sh_amt_c   = (leading_one > EXP_W'(MSB)) ? '0 : EXP_W'(MSB) - leading_one;
        sh_c       = al_sum_q << sh_amt_c;
        // Two zero bits below the LSB give a guard position even when MANT_W == SUM_W.
        ext_c      = {sh_c, 2'b00};
        mant_c     = ext_c[EXT_W-1 -: MANT_W];
        guard_c    = ext_c[EXT_W-1-MANT_W];
        sticky_c   = |ext_c[EXT_W-2-MANT_W:0];
        inc_c      = guard_c & (sticky_c | mant_c[0]);
        mant_rnd_c = {1'b0, mant_c} + (MANT_W+1)'(inc_c);

        res_c      = '0;
        if (al_sum_q != '0) begin
            res_c.sign = al_sign_q;
            if (mant_rnd_c[MANT_W]) begin
                // Rounding carried out of the mantissa: renormalize one position up.
                res_c.mant = MANT_W'(1) << (MANT_W - 1);
                res_c.exp  = leading_one + EXP_W'(1);
            end else begin
                res_c.mant = mant_rnd_c[MANT_W-1:0];
                res_c.exp  = leading_one;
            end
        end else begin
            res_c.zero = 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Output FIFO control
    // ---------------------------------------------------------------
    res_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             overflow_q, overflow_d;
    logic             out_valid_q, out_valid_d;
    logic             full_c;
    logic             pop_c;
    logic             push_c;

    always_comb begin
        full_c      = (count_q == CNT_W'(FIFO_DEPTH));
        pop_c       = out_valid_q & out_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_c      = al_valid_q & (~full_c | pop_c);
        wr_ptr_d    = push_c ? PTR_W'(wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d    = pop_c  ? PTR_W'(rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        count_d     = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        overflow_d  = overflow_q | (al_valid_q & full_c & ~pop_c);
        out_valid_d = (count_d != '0);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            al_valid_q  <= 1'b0;
            al_sign_q   <= 1'b0;
            al_sum_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            al_valid_q  <= al_valid_d;
            al_sign_q   <= al_sign_d;
            al_sum_q    <= al_sum_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    // FIFO storage; contents are only visible through a valid head
    always_ff @(posedge clk) begin
        if (!rst && push_c) begin
            mem_q[wr_ptr_q] <= res_c;
        end
    end

    // Head data is forced to zero whenever nothing is valid
    res_t head_c;

    always_comb begin
        head_c = '0;
        if (out_valid_q) begin
            head_c = mem_q[rd_ptr_q];
        end
    end

    assign out_valid = out_valid_q;
    assign out_sign  = head_c.sign;
    assign out_zero  = head_c.zero;
    assign out_exp   = head_c.exp;
    assign out_mant  = head_c.mant;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_sd4_sum_normalizer.sv
// Testbench for sd4_sum_normalizer (MANT_W=8, FIFO_DEPTH=2) with a registered
// leading-one detector model and a queue-based scoreboard.
module tb_sd4_sum_normalizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sign = 1'b0;
    logic [19:0] unsign_sum = '0;
    logic [4:0]  leading_one;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sign;
    logic        out_zero;
    logic [4:0]  out_exp;
    logic [7:0]  out_mant;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    logic [14:0] exp_q [$];
    logic [14:0] e_mon;

    always #5 clk = ~clk;

    sd4_sum_normalizer #(.SUM_W(20), .MANT_W(8), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sign(in_sign),
        .unsign_sum(unsign_sum), .leading_one(leading_one),
        .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
        .out_zero(out_zero), .out_exp(out_exp), .out_mant(out_mant),
        .overflow(overflow)
    );

    function automatic logic [4:0] msb_idx(input logic [19:0] v);
        logic [4:0] r = 5'd0;
        for (int i = 0; i < 20; i++) if (v[i]) r = 5'(i);
        return r;
    endfunction

    // Detector model: registered, no reset, one cycle behind unsign_sum
    always @(posedge clk) leading_one <= msb_idx(unsign_sum);

    // Reference: {sign, zero, exp[5], mant[8]}
    function automatic logic [14:0] ref_norm(input logic s, input logic [19:0] sum);
        int p, sh;
        longint m, rem, half;
        if (sum == 0) return {1'b0, 1'b1, 5'd0, 8'd0};
        p = int'(msb_idx(sum));
        if (p <= 7) begin
            m = longint'(sum) << (7 - p);
        end else begin
            sh   = p - 7;
            m    = longint'(sum) >> sh;
            rem  = longint'(sum) & ((64'sd1 << sh) - 1);
            half = 64'sd1 << (sh - 1);
            if (rem > half || (rem == half && m[0])) m = m + 1;
            if (m == 256) begin
                m = 128;
                p = p + 1;
            end
        end
        return {s, 1'b0, 5'(p), 8'(m)};
    endfunction

    // Scoreboard: compare every accepted head, and idle data when nothing is valid
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %h, none expected", {out_sign, out_zero, out_exp, out_mant});
            end else begin
                e_mon = exp_q.pop_front();
                if ({out_sign, out_zero, out_exp, out_mant} !== e_mon) begin
                    errors++;
                    $display("FAIL result: got %h, expected %h", {out_sign, out_zero, out_exp, out_mant}, e_mon);
                end
            end
        end
        if (!out_valid) begin
            checks++;
            if ({out_sign, out_zero, out_exp, out_mant} !== 15'd0) begin
                errors++;
                $display("FAIL idle_data: got %h, expected 0", {out_sign, out_zero, out_exp, out_mant});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [19:0] sum, input bit expect_out);
        in_valid   = 1'b1;
        in_sign    = s;
        unsign_sum = sum;
        if (expect_out) exp_q.push_back(ref_norm(s, sum));
        tick();
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_sign    = 1'b0;
        unsign_sum = '0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL %s_drain: pending=%0d out_valid=%b, expected 0/0", name, exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: out_valid=%b overflow=%b, expected 0/0", out_valid, overflow);
        end
        checks++;
        if ({out_sign, out_zero, out_exp, out_mant} !== 15'd0) begin
            errors++;
            $display("FAIL reset_data: got %h, expected 0", {out_sign, out_zero, out_exp, out_mant});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        drive(1'b0, 20'h00001, 1'b1);
        idle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: out_valid=%b at T+1, expected 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_exp !== 5'd0 || out_mant !== 8'h80 || out_zero !== 1'b0) begin
            errors++;
            $display("FAIL latency_t2: valid=%b exp=%0d mant=%h zero=%b, expected 1/0/80/0",
                     out_valid, out_exp, out_mant, out_zero);
        end
        wait_drain("latency");
    endtask

    task automatic test_rounding();
        logic [19:0] tbl [10];
        tbl = '{20'h00101, 20'h00103, 20'hFF800, 20'h80000, 20'h000FF,
                20'h00180, 20'h00181, 20'h00183, 20'hFFFFF, 20'h7FFFF};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) drive(1'(i), tbl[i], 1'b1);
        for (int i = 0; i < 24; i++) drive(1'($urandom), 20'($urandom) >> $urandom_range(0, 19), 1'b1);
        idle();
        wait_drain("rounding");
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        drive(1'b1, 20'h0, 1'b1);
        idle();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_zero !== 1'b1 || out_sign !== 1'b0 || out_exp !== 5'd0 || out_mant !== 8'd0) begin
            errors++;
            $display("FAIL zero: valid=%b zero=%b sign=%b exp=%0d mant=%h, expected 1/1/0/0/00",
                     out_valid, out_zero, out_sign, out_exp, out_mant);
        end
        wait_drain("zero");
    endtask

    task automatic test_full_push_pop();
        out_ready = 1'b0;
        drive(1'b0, 20'h00ABC, 1'b1);
        drive(1'b1, 20'h12345, 1'b1);
        drive(1'b0, 20'h00003, 1'b1);
        idle();
        out_ready = 1'b1;   // pop and push coincide on a full FIFO
        wait_drain("full_push_pop");
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop_overflow: overflow=%b, expected 0", overflow);
        end
    endtask

    task automatic test_overflow();
        logic [14:0] head;
        out_ready = 1'b0;
        drive(1'b0, 20'h00101, 1'b1);
        drive(1'b1, 20'h00103, 1'b1);
        drive(1'b0, 20'h55555, 1'b0);
        idle();
        tick();
        tick();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: overflow=%b, expected 1", overflow);
        end
        head = exp_q[0];
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || {out_sign, out_zero, out_exp, out_mant} !== head) begin
                errors++;
                $display("FAIL overflow_hold: valid=%b data=%h, expected 1/%h",
                         out_valid, {out_sign, out_zero, out_exp, out_mant}, head);
            end
            tick();
        end
        out_ready = 1'b1;
        wait_drain("overflow");
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: overflow=%b, expected 1", overflow);
        end
    endtask

    task automatic test_rst_midstream();
        out_ready = 1'b0;
        drive(1'b0, 20'h00011, 1'b0);
        drive(1'b0, 20'h00022, 1'b0);
        drive(1'b1, 20'h00033, 1'b0);
        rst = 1'b1;
        drive(1'b0, 20'h00044, 1'b0);
        rst = 1'b0;
        idle();
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: out_valid=%b overflow=%b, expected 0/0", out_valid, overflow);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale: out_valid=%b cycle %0d, expected 0", out_valid, i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_rounding();
        test_zero();
        test_full_push_pop();
        test_overflow();
        test_rst_midstream();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
